vinst_issue: RTL and testbench
==============================

Name: vinst_issue

Overview:
- Producer end of the `sa_inst_t` / `iavail` / `ird` instruction handshake.
- Buffers vector instructions written by the host/sequencer side in an in-order queue.
- Presents the head instruction to the array controller with `iavail` high, and retires it on each one-cycle `ird` pulse.
- Sits between the host command interface and the array control block; also reports queue occupancy and protocol errors.

Parameters:
- DEPTH, 8, total instruction capacity including the presented head entry; power of 2, ≥2.
- CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- hwr  in  1  host write strobe, one instruction per cycle
- hinst  in  sa_inst_t  host instruction, sampled when hwr=1
- hflush  in  1  discard all queued instructions, including the head
- hfull  out  1  queue full; hwr is ignored while high
- inst  out  sa_inst_t  head instruction, to the array controller
- iavail  out  1  inst is valid
- ird  in  1  one-cycle consume pulse from the array controller
- count  out  CW  occupancy, 0..DEPTH
- err  out  2  sticky flags: [0] ird while iavail=0, [1] hwr while hfull=1

Behaviour:
- Reset (reset=0 at a clk edge):
  - count=0, iavail=0, hfull=0, err=0.
  - inst.opcode=0 (NOP); other inst fields hold.
  - Reset mid-operation discards all entries.
- Storage and pointers:
  - Circular array of DEPTH entries with wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Output register holds the head. inst is driven from that register, never combinationally from the array.
- Derived outputs:
  - iavail is registered. iavail=1 exactly when count≥1 and the head register is loaded.
  - hfull = (count==DEPTH), registered together with count.
- State machine:
  - EMPTY: count==0. Moves to VALID when hwr=1 and hflush=0.
  - VALID: count≥1. Moves to EMPTY on ird with count==1 and hwr=0, or on hflush.
- Write latency: hwr while EMPTY → next cycle iavail=1, inst=hinst, count=1.
- Pop on ird while VALID:
  - If count>1: the next entry is in inst on the following cycle and iavail stays high (no bubble).
  - If count==1 and hwr=0: iavail=0 on the following cycle.
- Simultaneous hwr and ird:
  - count is unchanged.
  - At count==1, the written instruction becomes the head next cycle and iavail stays 1.
- hwr while hfull: write dropped; state unchanged; err[1] set.
  - hwr in the same cycle as an ird at count==DEPTH is still dropped, because hfull was high.
- ird while iavail=0: ignored, no underflow; err[0] set.
- hflush:
  - Highest priority after reset.
  - Clears count and pointers; iavail=0 next cycle.
  - A same-cycle hwr or ird is ignored.
  - err is not cleared; only reset clears it.
- Arithmetic: count changes by +1, -1 or 0 and never wraps. CW bits hold the value DEPTH.
- ird is a pulse: each cycle with ird=1 and iavail=1 retires exactly one entry.

Optional Feature:
- Macro: VINST_ISSUE_STATS_EN.
- Defined:
  - Adds output `issued` (32 bits): count of retired instructions.
  - Adds output `stall` (32 bits): cycles with count==0 while hwr=0.
  - Both saturate at all-ones, clear on reset, and do not clear on hflush.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- proj_pkgs:
  - sa_inst_t (existing).
  - New constant VINST_Q_DEPTH=8, used as the DEPTH default.
  - New enum vissue_state_t {EMPTY, VALID}.
- Sub-module: sa_inst_fifo_mem.
  - DEPTH x sa_inst_t register array.
  - Synchronous write; read address → registered data.
- vinst_issue owns the pointers, count, head register, FSM and error flags.

Test Plan:
- Reset, then one hwr with opcode=3, vsize=4 → next cycle iavail=1, inst.opcode=3, count=1; ird pulse → iavail=0 next cycle, count=0.
- 8 back-to-back hwr with DEPTH=8 → hfull=1 after the 8th. A 9th hwr → dropped, count=8, err=2'b10. Then 8 ird pulses spaced 3 cycles apart → instructions emerge in write order, iavail never drops between pulses, final count=0.
- count==1 with hwr and ird in the same cycle → iavail stays 1, inst shows the new instruction, count=1.
- ird with count==0 → count stays 0, err[0]=1, iavail=0.
- 5 entries queued, hflush with a simultaneous hwr → next cycle count=0, iavail=0, hfull=0. A subsequent hwr is presented 1 cycle later.
- reset asserted at count=6 → count=0, iavail=0, inst.opcode=0, err=0. With VINST_ISSUE_STATS_EN defined, issued=0.

Source files
------------

// File: rtl/vinst_issue_pkg.sv
// vinst_issue_pkg
//   Shared types and constants for the vector instruction issue queue.
//   - sa_inst_t      : instruction word passed from host to array controller
//   - VINST_Q_DEPTH  : default queue depth for vinst_issue
//   - vissue_state_t : issue-queue FSM states
//   - sat_inc32      : saturating 32-bit increment used by the statistics
//                      counters (VINST_ISSUE_STATS_EN builds)
package vinst_issue_pkg;

    localparam int VINST_Q_DEPTH = 8;

    localparam logic [3:0] OP_NOP = 4'd0;

    typedef struct packed {
        logic [3:0] opcode;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [7:0] vsize;
    } sa_inst_t;

    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } vissue_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/vinst_issue_fifo_mem.sv
// sa_inst_fifo_mem
//   DEPTH-entry instruction storage for vinst_issue.
//   Synchronous write; registered read of rd_addr. A write to the address
//   being read in the same cycle is forwarded, so rd_data always reflects
//   the array contents including that cycle's write.
// Ports:
//   clk      in   clock
//   wr_en    in   write enable
//   wr_addr  in   write address
//   wr_data  in   instruction to store
//   rd_addr  in   read address, sampled every cycle
//   rd_data  out  registered read data
module sa_inst_fifo_mem
    import vinst_issue_pkg::*;
#(
    parameter  int DEPTH = VINST_Q_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  sa_inst_t      wr_data,
    input  logic [AW-1:0] rd_addr,
    output sa_inst_t      rd_data
);

    sa_inst_t mem [DEPTH];

    // NOTE: the storage array is deliberately not reset; validity is tracked
    // by the pointers and count in the parent, so stale contents are never
    // observed and the array can map onto plain register files or RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end

endmodule

// File: rtl/vinst_issue.sv
// vinst_issue
//   In-order vector instruction issue queue. The host writes instructions
//   with hwr; the head is presented on inst with iavail, and each ird pulse
//   retires it. inst comes from a dedicated head register. The memory
//   prefetches the entry after the next head so a pop at count>1 refills the
//   head register without a bubble.
// Optional: define VINST_ISSUE_STATS_EN to add the issued/stall counters.
// Ports:
//   clk     in   clock
//   reset   in   synchronous active-low reset
//   hwr     in   host write strobe
//   hinst   in   host instruction, sampled when hwr=1
//   hflush  in   discard all queued instructions
//   hfull   out  queue full (hwr ignored while high)
//   inst    out  head instruction
//   iavail  out  inst is valid
//   ird     in   one-cycle consume pulse
//   count   out  occupancy 0..DEPTH
//   err     out  sticky: [0] ird while !iavail, [1] hwr while hfull
//   issued  out  (stats) retired instructions, saturating
//   stall   out  (stats) cycles with count==0 and hwr=0, saturating
module vinst_issue
    import vinst_issue_pkg::*;
#(
    parameter int DEPTH = VINST_Q_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hwr,
    input  sa_inst_t      hinst,
    input  logic          hflush,
    output logic          hfull,
    output sa_inst_t      inst,
    output logic          iavail,
    input  logic          ird,
    output logic [CW-1:0] count,
    output logic [1:0]    err
`ifdef VINST_ISSUE_STATS_EN
    ,
    output logic [31:0]   issued,
    output logic [31:0]   stall
`endif
);

    localparam int AW = $clog2(DEPTH);

    vissue_state_t state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_d;
    logic          hfull_d;
    logic [1:0]    err_d;
    sa_inst_t      head_d;
    sa_inst_t      pre_data;
    logic          wr_acc;
    logic          pop;

    assign iavail = (state_q == VALID);

    // The read port is addressed one past the *next* head, so after a pop
    // pre_data already holds the entry that follows the new head.
    sa_inst_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (hinst),
        .rd_addr (rd_ptr_d + AW'(1)),
        .rd_data (pre_data)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        wr_acc   = hwr && !hfull && !hflush;
        pop      = ird && iavail && !hflush;
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count;
        head_d   = inst;
        err_d    = err | {hwr && hfull, ird && !iavail};

        if (hflush) begin
            state_d  = EMPTY;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);

            case ({wr_acc, pop})
                2'b10:   count_d = count + CW'(1);
                2'b01:   count_d = count - CW'(1);
                default: count_d = count;
            endcase

            case (state_q)
                EMPTY: begin
                    if (wr_acc) begin
                        state_d = VALID;
                        head_d  = hinst;
                    end
                end
                VALID: begin
                    if (pop) begin
                        if (count > CW'(1)) begin
                            head_d = pre_data;
                        end else if (wr_acc) begin
                            // Last entry leaves as a new one arrives.
                            head_d = hinst;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        hfull_d = (count_d == CW'(DEPTH));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count       <= '0;
            hfull       <= 1'b0;
            err         <= 2'b00;
            inst.opcode <= OP_NOP;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count    <= count_d;
            hfull    <= hfull_d;
            err      <= err_d;
            inst     <= head_d;
        end
    end

`ifdef VINST_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            issued <= '0;
            stall  <= '0;
        end else begin
            if (pop) issued <= sat_inc32(issued);
            if ((count == '0) && !hwr) stall <= sat_inc32(stall);
        end
    end
`endif

endmodule

// File: tb/tb_vinst_issue.sv
// tb_vinst_issue
//   Table-driven bench for vinst_issue (DEPTH=8). Each record is applied for
//   one clock; outputs are compared 1 time unit after the edge. Hand-written
//   sequences cover the startup reset and reset in the middle of operation.
module tb_vinst_issue;
    import vinst_issue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          hwr;
    sa_inst_t      hinst;
    logic          hflush;
    logic          hfull;
    sa_inst_t      inst;
    logic          iavail;
    logic          ird;
    logic [CW-1:0] count;
    logic [1:0]    err;
`ifdef VINST_ISSUE_STATS_EN
    logic [31:0]   issued;
    logic [31:0]   stall;
`endif

    always #5 clk = ~clk;

    vinst_issue #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .hwr    (hwr),
        .hinst  (hinst),
        .hflush (hflush),
        .hfull  (hfull),
        .inst   (inst),
        .iavail (iavail),
        .ird    (ird),
        .count  (count),
        .err    (err)
`ifdef VINST_ISSUE_STATS_EN
        ,
        .issued (issued),
        .stall  (stall)
`endif
    );

    typedef struct {
        string      name;
        logic       hwr;
        logic [3:0] op;
        logic [7:0] vsz;
        logic       hflush;
        logic       ird;
        logic       e_iavail;
        logic [3:0] e_op;
        logic [7:0] e_vsz;
        int         e_count;
        logic       e_hfull;
        logic [1:0] e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input string name, input logic w, input int op, input int vsz,
                       input logic fl, input logic r, input logic e_av, input int e_op,
                       input int e_vsz, input int e_cnt, input logic e_hf, input logic [1:0] e_er);
        vec_t v;
        v.name = name;   v.hwr = w;  v.op = 4'(op);  v.vsz = 8'(vsz);
        v.hflush = fl;   v.ird = r;
        v.e_iavail = e_av; v.e_op = 4'(e_op); v.e_vsz = 8'(e_vsz);
        v.e_count = e_cnt; v.e_hfull = e_hf; v.e_err = e_er;
        vecs.push_back(v);
    endtask

    function automatic sa_inst_t mk(input logic [3:0] op, input logic [7:0] vsz);
        sa_inst_t i;
        i.opcode = op;
        i.vd     = 5'd1;
        i.vs1    = 5'd2;
        i.vsize  = vsz;
        return i;
    endfunction

    // Drive one cycle of inputs at the falling edge, let the rising edge take them.
    task automatic cycle(input logic w, input sa_inst_t hi, input logic fl, input logic r);
        @(negedge clk);
        hwr = w; hinst = hi; hflush = fl; ird = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name, input logic e_av, input logic [3:0] e_op,
                                 input logic [7:0] e_vsz, input int e_cnt, input logic e_hf,
                                 input logic [1:0] e_er);
        check({name, ".iavail"}, 32'(iavail), 32'(e_av));
        check({name, ".count"},  32'(count),  32'(e_cnt));
        check({name, ".hfull"},  32'(hfull),  32'(e_hf));
        check({name, ".err"},    32'(err),    32'(e_er));
        if (e_av) begin
            check({name, ".opcode"}, 32'(inst.opcode), 32'(e_op));
            check({name, ".vsize"},  32'(inst.vsize),  32'(e_vsz));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single instruction in and out.
        add("w1",        1, 3, 4,  0, 0,  1, 3, 4,   1, 0, 2'b00);
        add("r1",        0, 0, 0,  0, 1,  0, 0, 0,   0, 0, 2'b00);
        add("idle",      0, 0, 0,  0, 0,  0, 0, 0,   0, 0, 2'b00);
        // Fill to DEPTH; head stays the first instruction.
        for (int i = 1; i <= DEPTH; i++)
            add("fill",  1, i, i + 16, 0, 0,  1, 1, 17,  i, (i == DEPTH), 2'b00);
        add("ovf",       1, 9, 25, 0, 0,  1, 1, 17,  8, 1, 2'b10);
        // Write with ird at full: pop happens, write is dropped.
        add("full_wr_rd",1, 10, 26, 0, 1, 1, 2, 18,  7, 0, 2'b10);
        add("gap",       0, 0, 0,  0, 0,  1, 2, 18,  7, 0, 2'b10);
        add("gap",       0, 0, 0,  0, 0,  1, 2, 18,  7, 0, 2'b10);
        // Drain: pops three cycles apart, write order preserved, no bubble.
        for (int k = 2; k <= DEPTH; k++) begin
            add("pop",   0, 0, 0,  0, 1,  (k < DEPTH), k + 1, k + 17, DEPTH - k, 0, 2'b10);
            add("gap",   0, 0, 0,  0, 0,  (k < DEPTH), k + 1, k + 17, DEPTH - k, 0, 2'b10);
            add("gap",   0, 0, 0,  0, 0,  (k < DEPTH), k + 1, k + 17, DEPTH - k, 0, 2'b10);
        end
        // Simultaneous write and read at count==1.
        add("wr_a",      1, 5, 21, 0, 0,  1, 5, 21,  1, 0, 2'b10);
        add("wr_rd_c1",  1, 6, 22, 0, 1,  1, 6, 22,  1, 0, 2'b10);
        add("rd_last",   0, 0, 0,  0, 1,  0, 0, 0,   0, 0, 2'b10);
        // Underflow attempt.
        add("rd_empty",  0, 0, 0,  0, 1,  0, 0, 0,   0, 0, 2'b11);
        // Five queued, then flush with a same-cycle write.
        for (int i = 1; i <= 5; i++)
            add("q5",    1, i, i + 32, 0, 0,  1, 1, 33,  i, 0, 2'b11);
        add("flush_wr",  1, 7, 39, 1, 0,  0, 0, 0,   0, 0, 2'b11);
        add("wr_after",  1, 8, 40, 0, 0,  1, 8, 40,  1, 0, 2'b11);
        // Second entry written the cycle before the pop that exposes it.
        add("wr_2nd",    1, 9, 41, 0, 0,  1, 8, 40,  2, 0, 2'b11);
        add("rd_fwd",    0, 0, 0,  0, 1,  1, 9, 41,  1, 0, 2'b11);
        add("rd_end",    0, 0, 0,  0, 1,  0, 0, 0,   0, 0, 2'b11);

        // Startup reset.
        reset = 1'b0; hwr = 1'b0; hinst = mk(4'd15, 8'd99); hflush = 1'b0; ird = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 4'd0, 8'd0, 0, 1'b0, 2'b00);
        check("reset.opcode", 32'(inst.opcode), 32'(OP_NOP));
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].hwr, mk(vecs[i].op, vecs[i].vsz), vecs[i].hflush, vecs[i].ird);
            check_outputs($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].e_iavail, vecs[i].e_op,
                          vecs[i].e_vsz, vecs[i].e_count, vecs[i].e_hfull, vecs[i].e_err);
        end

        // Reset with six entries queued; a same-cycle write must not survive.
        for (int i = 1; i <= 6; i++) cycle(1'b1, mk(4'(i), 8'(i + 48)), 1'b0, 1'b0);
        check_outputs("pre_rst", 1'b1, 4'd1, 8'd49, 6, 1'b0, 2'b11);
        @(negedge clk);
        reset = 1'b0; hwr = 1'b1; hinst = mk(4'd12, 8'd60);
        @(posedge clk);
        #1;
        check_outputs("mid_rst", 1'b0, 4'd0, 8'd0, 0, 1'b0, 2'b00);
        check("mid_rst.opcode", 32'(inst.opcode), 32'(OP_NOP));
`ifdef VINST_ISSUE_STATS_EN
        check("mid_rst.issued", issued, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1; hwr = 1'b0;
        cycle(1'b1, mk(4'd13, 8'd61), 1'b0, 1'b0);
        check_outputs("post_rst_wr", 1'b1, 4'd13, 8'd61, 1, 1'b0, 2'b00);
        cycle(1'b0, mk(4'd0, 8'd0), 1'b0, 1'b1);
        check_outputs("post_rst_rd", 1'b0, 4'd0, 8'd0, 0, 1'b0, 2'b00);
`ifdef VINST_ISSUE_STATS_EN
        check("post_rst.issued", issued, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
